// File: rtl/binary_to_2s.sv
// Registered two's-complement negator: out = (~data) + 1 one clock after in_valid,
// with registered flags for the zero and most-negative (non-negatable) inputs.
module binary_to_2s #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [WIDTH-1:0]        data,
  output logic signed [WIDTH-1:0] out,
  output logic                    out_valid,
  output logic                    zero,
  output logic                    ovf
);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] inv;
  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] result;
  logic             zero_n;
  logic             ovf_n;

  // Ripple incrementer on the inverted word; carry out of the MSB is dropped.
  always_comb begin
    inv      = ~data;
    carry    = '0;
    carry[0] = 1'b1;
    for (int unsigned i = 1; i < WIDTH; i++) begin
      carry[i] = carry[i-1] & inv[i-1];
    end
    result = inv ^ carry;
    zero_n = (data == '0);
    ovf_n  = (data == MOST_NEG);
  end

  // Output stage: reset wins over in_valid; payload and flags hold when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= '0;
      out_valid <= 1'b0;
      zero      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out  <= result;
        zero <= zero_n;
        ovf  <= ovf_n;
      end
    end
  end

endmodule

// File: tb/tb_binary_to_2s.sv
// Scoreboard bench for binary_to_2s: WIDTH=4 and WIDTH=8 instances share clock and reset;
// the driver queues expected results, negedge monitors pop them on out_valid.
module tb_binary_to_2s;

  typedef struct packed {
    logic [7:0] o;
    logic       z;
    logic       v;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       iv4 = 1'b0;
  logic [3:0] d4  = '0;
  logic       iv8 = 1'b0;
  logic [7:0] d8  = '0;

  logic [3:0] o4;
  logic       ov4, z4, f4;
  logic [7:0] o8;
  logic       ov8, z8, f8;

  exp_t q4[$];
  exp_t q8[$];
  exp_t h4, h8;
  logic rst_q   = 1'b0;
  bit   started = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  binary_to_2s #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .data(d4),
    .out(o4), .out_valid(ov4), .zero(z4), .ovf(f4)
  );

  binary_to_2s #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .data(d8),
    .out(o8), .out_valid(ov8), .zero(z8), .ovf(f8)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rst_q <= rst;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor for the 4-bit instance.
  always @(negedge clk) begin
    if (started) begin
      if (rst_q) begin
        chk("w4 reset out_valid", 32'(ov4), 32'(0));
        chk("w4 reset out", 32'(o4), 32'(0));
        chk("w4 reset flags", {30'b0, z4, f4}, 32'(0));
        h4 = '0;
      end else if (ov4) begin
        if (q4.size() == 0) begin
          chk("w4 unexpected out_valid", 32'(1), 32'(0));
        end else begin
          h4 = q4.pop_front();
          chk("w4 out", 32'(o4), 32'(h4.o[3:0]));
          chk("w4 zero", 32'(z4), 32'(h4.z));
          chk("w4 ovf", 32'(f4), 32'(h4.v));
        end
      end else begin
        chk("w4 hold out", 32'(o4), 32'(h4.o[3:0]));
        chk("w4 hold flags", {30'b0, z4, f4}, {30'b0, h4.z, h4.v});
      end
    end
  end

  // Monitor for the 8-bit instance.
  always @(negedge clk) begin
    if (started) begin
      if (rst_q) begin
        chk("w8 reset out_valid", 32'(ov8), 32'(0));
        chk("w8 reset out", 32'(o8), 32'(0));
        chk("w8 reset flags", {30'b0, z8, f8}, 32'(0));
        h8 = '0;
      end else if (ov8) begin
        if (q8.size() == 0) begin
          chk("w8 unexpected out_valid", 32'(1), 32'(0));
        end else begin
          h8 = q8.pop_front();
          chk("w8 out", 32'(o8), 32'(h8.o));
          chk("w8 zero", 32'(z8), 32'(h8.z));
          chk("w8 ovf", 32'(f8), 32'(h8.v));
        end
      end else begin
        chk("w8 hold out", 32'(o8), 32'(h8.o));
        chk("w8 hold flags", {30'b0, z8, f8}, {30'b0, h8.z, h8.v});
      end
    end
  end

  // One clock of stimulus; e4/e8 are the hand-computed negations.
  task automatic step(input logic r,
                      input logic v4, input logic [3:0] a4, input logic [3:0] e4,
                      input logic v8, input logic [7:0] a8, input logic [7:0] e8);
    @(posedge clk);
    #1;
    rst = r;
    iv4 = v4;
    d4  = a4;
    iv8 = v8;
    d8  = a8;
    if (v4 && !r) q4.push_back('{o: {4'b0, e4}, z: (a4 == 4'h0), v: (a4 == 4'h8)});
    if (v8 && !r) q8.push_back('{o: e8, z: (a8 == 8'h00), v: (a8 == 8'h80)});
  endtask

  logic [3:0] sweep_exp [16] = '{4'h0, 4'hF, 4'hE, 4'hD, 4'hC, 4'hB, 4'hA, 4'h9,
                                 4'h8, 4'h7, 4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1};
  logic [7:0] v8_in  [6] = '{8'h01, 8'h80, 8'h7F, 8'h00, 8'hFF, 8'h05};
  logic [7:0] v8_exp [6] = '{8'hFF, 8'h80, 8'h81, 8'h00, 8'h01, 8'hFB};

  initial begin
    h4 = '0;
    h8 = '0;
    // Reset held with live input that must be dropped.
    @(posedge clk);
    #1;
    started = 1'b1;
    iv4 = 1'b1;
    d4  = 4'd5;
    iv8 = 1'b1;
    d8  = 8'd5;
    step(1'b1, 1'b1, 4'd5, 4'hB, 1'b1, 8'd5, 8'hFB);
    // Full 4-bit sweep back-to-back, 8-bit vectors alongside.
    for (int i = 0; i < 16; i++) begin
      if (i < 6) step(1'b0, 1'b1, 4'(i), sweep_exp[i], 1'b1, v8_in[i], v8_exp[i]);
      else       step(1'b0, 1'b1, 4'(i), sweep_exp[i], 1'b0, 8'hAA, 8'h00);
    end
    // Boundary spot checks.
    step(1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 8'h00, 8'h00);
    step(1'b0, 1'b1, 4'h8, 4'h8, 1'b1, 8'h80, 8'h80);
    step(1'b0, 1'b1, 4'hF, 4'h1, 1'b0, 8'h00, 8'h00);
    step(1'b0, 1'b1, 4'h7, 4'h9, 1'b0, 8'h00, 8'h00);
    // Single result followed by an idle gap with toggling data.
    step(1'b0, 1'b1, 4'h3, 4'hD, 1'b0, 8'h00, 8'h00);
    step(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 8'h33, 8'h00);
    step(1'b0, 1'b0, 4'h8, 4'h0, 1'b0, 8'h80, 8'h00);
    step(1'b0, 1'b0, 4'hF, 4'h0, 1'b0, 8'h00, 8'h00);
    // Reset colliding with a valid input, then recovery.
    step(1'b1, 1'b1, 4'h2, 4'hE, 1'b1, 8'h02, 8'hFE);
    step(1'b0, 1'b1, 4'h2, 4'hE, 1'b1, 8'h7F, 8'h81);
    step(1'b0, 1'b0, 4'h9, 4'h0, 1'b0, 8'h00, 8'h00);
    step(1'b0, 1'b0, 4'h9, 4'h0, 1'b0, 8'h00, 8'h00);
    step(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    chk("w4 results outstanding", 32'(q4.size()), 32'(0));
    chk("w8 results outstanding", 32'(q8.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
